pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central hazard and pipeline-control block for the 5-stage RISC-V core. It is the driver side of the stall/flush interface consumed by the F/D, D/E, E/M and M/W pipeline registers. It resolves data hazards by forwarding and load-use stalls, and control hazards by flushing. It also freezes the pipeline while data memory inserts wait states, bounds each wait with a watchdog, and keeps two performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum consecutive data-memory wait cycles before a forced release; legal range 2..255.

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- Rs1D, Rs2D  in  5  source registers in Decode
- Rs1E, Rs2E, RdE  in  5  sources and destination in Execute
- ResultSrcE  in  2  result select in Execute; 01 means load
- PCSrcE  in  1  taken branch or jump resolved in Execute
- RdM, RdW  in  5  destinations in Memory and Writeback
- RegWriteM, RegWriteW  in  1  register-write enables in Memory and Writeback
- MemAccessM  in  1  load or store present in Memory
- DMemReadyM  in  1  data memory completes access this cycle
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 register file, 10 Memory result, 01 Writeback result
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  clear control fields of the D, E and W pipeline registers
- MemTimeoutM  out  1  one-cycle pulse when the watchdog forces a release
- StallCycles  out  32  count of cycles with StallF=1
- FlushCount  out  32  count of cycles with FlushD=1

## Operation
- Forwarding (operand A; operand B is identical using Rs2E):
  - ForwardAE=10 if RegWriteM, RdM!=0 and RdM==Rs1E.
  - Otherwise 01 if RegWriteW, RdW!=0 and RdW==Rs1E.
  - Otherwise 00. Memory beats Writeback.
- lwStall = (ResultSrcE==01) and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
- memStall = state WAIT-capable condition: MemAccessM and not DMemReadyM and not timeout_hit.
- Output equations:
  - StallF = StallD = lwStall or memStall.
  - StallE = StallM = memStall.
  - FlushE = (lwStall or PCSrcE) and not memStall.
  - FlushD = PCSrcE and not memStall.
  - FlushW = memStall.
- While memStall is high, PCSrcE is deferred, not lost. E is held, so PCSrcE stays asserted and the flush fires on the release cycle.
- FSM states: RUN, WAIT.
  - RUN to WAIT when memStall.
  - WAIT to RUN when DMemReadyM or timeout_hit.
  - WAIT to WAIT otherwise.
- Watchdog:
  - wait_cnt is 8 bits. It clears in RUN and increments each WAIT cycle.
  - timeout_hit = (state==WAIT) and (wait_cnt==MEM_TIMEOUT-1).
  - On timeout_hit, memStall drops for that cycle, MemTimeoutM is registered high for the next cycle only, and the FSM returns to RUN.
- Counters are 32-bit, free-running and wrap from 0xFFFFFFFF to 0.

## Timing
- Forward, stall and flush outputs are combinational from the inputs and current state, with zero-cycle latency.
- MemTimeoutM, the counters, state and wait_cnt are registered.
- Reset (async, asserted):
  - State RUN, wait_cnt=0, MemTimeoutM=0, StallCycles=0, FlushCount=0.
  - All stall, flush and forward outputs are driven 0 while rst is high, regardless of inputs.
- Reset mid-WAIT: the FSM returns to RUN immediately and no timeout pulse is issued.
- Simultaneous events:
  - memStall together with lwStall: memStall governs E and M. FlushE is suppressed, because E is held.
  - DMemReadyM in the same cycle as timeout_hit: treated as normal completion; no MemTimeoutM pulse.
- A load-use hazard adds exactly one bubble. A taken branch costs exactly two flushed slots (D and E).

## Structure
- pipeline_ctrl_pkg holds:
  - ResultSrc encodings (ALU=00, MEM=01, PC4=10).
  - Forward-select encodings (FWD_RF=00, FWD_WB=01, FWD_MEM=10).
  - FSM state enum.
- One sub-module, hazard_forward_unit, is purely combinational and produces ForwardAE, ForwardBE and lwStall.
- The FSM, watchdog, output combination and counters live in the top module.

## Test plan
- Forwarding priority: RdM=RdW=Rs1E=5, both RegWrite=1, so ForwardAE=10. Change RdM to 0, so ForwardAE=01. Change Rs1E to 0 with RdW=0, so ForwardAE=00.
- Load-use: ResultSrcE=01, RdE=3, Rs2D=3, so StallF=StallD=FlushE=1 for one cycle and StallCycles increments by 1. With RdE=0 there is no stall.
- Branch: PCSrcE=1 with no memory access, so FlushD=FlushE=1 and FlushCount increments by 1. Apply the same with memStall active: no flush until the cycle DMemReadyM=1.
- Memory wait: MemAccessM=1 with DMemReadyM low for 3 cycles, so StallF/D/E/M=1 and FlushW=1 for 3 cycles, then release with StallCycles=3.
- Watchdog: MEM_TIMEOUT=4 and DMemReadyM never asserted, so stalls are high for 3 cycles, release on the 4th cycle, and MemTimeoutM pulses exactly once on the following cycle.
- Async reset asserted mid-WAIT: all outputs go to 0 immediately. After deassertion, state is RUN and both counters read 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller and its forwarding unit.
// Holds the result-select and forward-select codes, the FSM states and the forwarding priority rule.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // The Memory stage holds the younger value, so it wins over Writeback.
  function automatic fwd_sel_e fwd_select(input logic [4:0] rs,
                                          input logic [4:0] rd_m,
                                          input logic       reg_write_m,
                                          input logic [4:0] rd_w,
                                          input logic       reg_write_w);
    if (reg_write_m && (rd_m != REG_ZERO) && (rd_m == rs)) return FWD_MEM;
    if (reg_write_w && (rd_w != REG_ZERO) && (rd_w == rs)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// Combinational operand forwarding and load-use detection for the Execute stage.
module hazard_forward_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [1:0] ResultSrcE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       lw_stall
);

  assign ForwardAE = fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

  // A load in Execute cannot forward in time to an instruction in Decode that reads it.
  assign lw_stall = (ResultSrcE == RES_MEM) && (RdE != REG_ZERO) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush driver for the 5-stage core: forwarding, load-use stalls, branch flushes,
// data-memory wait freeze with a watchdog, and stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemAccessM,
  input  logic        DMemReadyM,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic        MemTimeoutM,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        lw_stall;
  logic        mem_stall;
  logic        timeout_hit;
  ctrl_state_e state;
  logic [7:0]  wait_cnt;

  hazard_forward_unit u_fwd (
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .ResultSrcE (ResultSrcE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .ForwardAE  (fwd_a),
    .ForwardBE  (fwd_b),
    .lw_stall   (lw_stall)
  );

  assign timeout_hit = (state == WAIT) && (wait_cnt == TIMEOUT_LAST);
  assign mem_stall   = MemAccessM && !DMemReadyM && !timeout_hit;

  // A held Execute keeps PCSrcE asserted, so suppressing flushes here only defers them.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (!rst) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      StallF    = lw_stall || mem_stall;
      StallD    = lw_stall || mem_stall;
      StallE    = mem_stall;
      StallM    = mem_stall;
      FlushD    = PCSrcE && !mem_stall;
      FlushE    = (lw_stall || PCSrcE) && !mem_stall;
      FlushW    = mem_stall;
    end
  end

  // wait_cnt counts stalled cycles of the current access, including the one spent entering WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      MemTimeoutM <= 1'b0;
    end else begin
      MemTimeoutM <= timeout_hit && !DMemReadyM;
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= WAIT;
            wait_cnt <= 8'd1;
          end else begin
            wait_cnt <= 8'd0;
          end
        end
        WAIT: begin
          if (DMemReadyM || timeout_hit) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCycles <= 32'd0;
      FlushCount  <= 32'd0;
    end else begin
      if (StallF) StallCycles <= StallCycles + 32'd1;
      if (FlushD) FlushCount  <= FlushCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE, RegWriteM, RegWriteW, MemAccessM, DMemReadyM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeoutM;
  logic [31:0] StallCycles, FlushCount;
  logic [10:0] dut_pack;

  int          vectors;
  int          miscompares;

  int          m_k;
  bit          m_pulse;
  logic [31:0] m_stall;
  logic [31:0] m_flush;
  logic [1:0]  e_fa, e_fb;
  bit          e_lw, e_hit, e_mem, e_stall_fd, e_flush_d, e_flush_e;
  logic [10:0] e_pack;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemAccessM(MemAccessM), .DMemReadyM(DMemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemTimeoutM(MemTimeoutM), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  assign dut_pack = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // m_k is how many cycles the current memory access has already been held.
  task automatic compute_expected();
    e_fa       = fwd_model(Rs1E);
    e_fb       = fwd_model(Rs2E);
    e_lw       = (ResultSrcE == 2'b01) && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
    e_hit      = (m_k == TMO - 1);
    e_mem      = MemAccessM && !DMemReadyM && !e_hit;
    e_stall_fd = e_lw || e_mem;
    e_flush_d  = PCSrcE && !e_mem;
    e_flush_e  = (e_lw || PCSrcE) && !e_mem;
    e_pack     = {e_fa, e_fb, e_stall_fd, e_stall_fd, e_mem, e_mem, e_flush_d, e_flush_e, e_mem};
  endtask

  task automatic model_reset();
    m_k = 0; m_pulse = 0; m_stall = 32'd0; m_flush = 32'd0;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    compute_expected();
    @(posedge clk);
    m_pulse = e_hit && !DMemReadyM;
    if (e_stall_fd) m_stall = m_stall + 32'd1;
    if (e_flush_d)  m_flush = m_flush + 32'd1;
    m_k = e_mem ? m_k + 1 : 0;
    #1;
  endtask

  task automatic set_idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 2'b00; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    MemAccessM = 0; DMemReadyM = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    Rs1E = 5; RdM = 5; RegWriteM = 1; PCSrcE = 1; MemAccessM = 1; DMemReadyM = 0;
    ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
    #2;
    vectors++;
    if (dut_pack !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %0h expected 0", dut_pack);
    end
    vectors++;
    if (StallCycles !== 32'd0 || FlushCount !== 32'd0 || MemTimeoutM !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_regs: got %0h/%0h/%0b expected 0/0/0", StallCycles, FlushCount, MemTimeoutM);
    end
    set_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_forwarding();
    RdM = 5; RdW = 5; Rs1E = 5; RegWriteM = 1; RegWriteW = 1; #1;
    vectors++;
    if (ForwardAE !== 2'b10) begin miscompares++; $display("[TB] FAIL fwd_mem_priority: got %b expected 10", ForwardAE); end
    RdM = 0; #1;
    vectors++;
    if (ForwardAE !== 2'b01) begin miscompares++; $display("[TB] FAIL fwd_wb: got %b expected 01", ForwardAE); end
    Rs1E = 0; RdW = 0; #1;
    vectors++;
    if (ForwardAE !== 2'b00) begin miscompares++; $display("[TB] FAIL fwd_none: got %b expected 00", ForwardAE); end
    Rs2E = 7; RdW = 7; RdM = 7; RegWriteM = 0; #1;
    vectors++;
    if (ForwardBE !== 2'b01 || ForwardAE !== 2'b00) begin
      miscompares++; $display("[TB] FAIL fwd_b_wb: got %b/%b expected 01/00", ForwardBE, ForwardAE);
    end
    tick();
    set_idle();
  endtask

  task automatic test_load_use();
    logic [31:0] s0;
    s0 = m_stall;
    ResultSrcE = 2'b01; RdE = 3; Rs2D = 3; #1;
    vectors++;
    if ({StallF, StallD, FlushE, StallE, FlushD} !== 5'b11100) begin
      miscompares++; $display("[TB] FAIL load_use: got %b expected 11100", {StallF, StallD, FlushE, StallE, FlushD});
    end
    tick();
    vectors++;
    if (StallCycles !== s0 + 32'd1) begin
      miscompares++; $display("[TB] FAIL load_use_count: got %0d expected %0d", StallCycles, s0 + 32'd1);
    end
    RdE = 0; Rs2D = 0; #1;
    vectors++;
    if (StallF !== 1'b0 || FlushE !== 1'b0) begin
      miscompares++; $display("[TB] FAIL load_use_x0: got %b%b expected 00", StallF, FlushE);
    end
    tick();
    set_idle();
  endtask

  task automatic test_branch();
    logic [31:0] f0;
    f0 = m_flush;
    PCSrcE = 1; #1;
    vectors++;
    if ({FlushD, FlushE, StallF} !== 3'b110) begin
      miscompares++; $display("[TB] FAIL branch_flush: got %b expected 110", {FlushD, FlushE, StallF});
    end
    tick();
    vectors++;
    if (FlushCount !== f0 + 32'd1) begin
      miscompares++; $display("[TB] FAIL branch_count: got %0d expected %0d", FlushCount, f0 + 32'd1);
    end
    MemAccessM = 1; DMemReadyM = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if ({FlushD, FlushE, StallF} !== 3'b001) begin
        miscompares++; $display("[TB] FAIL branch_deferred c%0d: got %b expected 001", c, {FlushD, FlushE, StallF});
      end
      tick();
    end
    DMemReadyM = 1; #1;
    vectors++;
    if ({FlushD, FlushE, StallF} !== 3'b110) begin
      miscompares++; $display("[TB] FAIL branch_release: got %b expected 110", {FlushD, FlushE, StallF});
    end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_mem_wait();
    logic [31:0] s0;
    s0 = m_stall;
    MemAccessM = 1; DMemReadyM = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if ({StallF, StallD, StallE, StallM, FlushW} !== 5'b11111) begin
        miscompares++; $display("[TB] FAIL mem_wait c%0d: got %b expected 11111", c, {StallF, StallD, StallE, StallM, FlushW});
      end
      tick();
    end
    DMemReadyM = 1; #1;
    vectors++;
    if ({StallF, StallD, StallE, StallM, FlushW} !== 5'b00000) begin
      miscompares++; $display("[TB] FAIL mem_release: got %b expected 00000", {StallF, StallD, StallE, StallM, FlushW});
    end
    tick();
    vectors++;
    if (StallCycles !== s0 + 32'd3 || MemTimeoutM !== 1'b0) begin
      miscompares++; $display("[TB] FAIL mem_wait_count: got %0d/%b expected %0d/0", StallCycles, MemTimeoutM, s0 + 32'd3);
    end
    set_idle();
    tick();
  endtask

  // Ready never arrives: stall TMO-1 cycles, forced release, then a single pulse.
  task automatic test_watchdog(input string tag);
    int pulses;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      MemAccessM = (c < TMO);
      DMemReadyM = 0;
      #1;
      vectors++;
      if (StallF !== (c < TMO - 1) || StallM !== (c < TMO - 1)) begin
        miscompares++; $display("[TB] FAIL %s_stall c%0d: got %b%b expected %b", tag, c, StallF, StallM, (c < TMO - 1));
      end
      vectors++;
      if (MemTimeoutM !== (c == TMO)) begin
        miscompares++; $display("[TB] FAIL %s_pulse c%0d: got %b expected %b", tag, c, MemTimeoutM, (c == TMO));
      end
      if (MemTimeoutM === 1'b1) pulses++;
      tick();
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++; $display("[TB] FAIL %s_pulse_count: got %0d expected 1", tag, pulses);
    end
    set_idle();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
      Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
      RdE  = 5'($urandom_range(0, 7)); RdM  = 5'($urandom_range(0, 7));
      RdW  = 5'($urandom_range(0, 7));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE    = ($urandom_range(0, 4) == 0);
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      if (m_k > 0) begin
        MemAccessM = 1;
        DMemReadyM = ($urandom_range(0, 3) == 0);
      end else begin
        MemAccessM = ($urandom_range(0, 2) == 0);
        DMemReadyM = 1'($urandom_range(0, 1));
      end
      compute_expected();
      #1;
      vectors++;
      if (dut_pack !== e_pack) begin
        miscompares++; $display("[TB] FAIL rand_comb i%0d: got %b expected %b", i, dut_pack, e_pack);
      end
      tick();
      vectors++;
      if (MemTimeoutM !== m_pulse) begin
        miscompares++; $display("[TB] FAIL rand_timeout i%0d: got %b expected %b", i, MemTimeoutM, m_pulse);
      end
      vectors++;
      if (StallCycles !== m_stall || FlushCount !== m_flush) begin
        miscompares++; $display("[TB] FAIL rand_counters i%0d: got %0d/%0d expected %0d/%0d", i, StallCycles, FlushCount, m_stall, m_flush);
      end
    end
    set_idle();
    while (m_k > 0) tick();
    tick();
  endtask

  task automatic test_reset_mid_wait();
    MemAccessM = 1; DMemReadyM = 0; PCSrcE = 1;
    ResultSrcE = 2'b01; RdE = 4; Rs1D = 4; Rs1E = 6; RdM = 6; RegWriteM = 1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (dut_pack !== 11'd0 || MemTimeoutM !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_mid_wait_outputs: got %0h/%b expected 0/0", dut_pack, MemTimeoutM);
    end
    vectors++;
    if (StallCycles !== 32'd0 || FlushCount !== 32'd0) begin
      miscompares++; $display("[TB] FAIL reset_mid_wait_counters: got %0d/%0d expected 0/0", StallCycles, FlushCount);
    end
    set_idle();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (StallCycles !== 32'd0 || FlushCount !== 32'd0 || MemTimeoutM !== 1'b0) begin
      miscompares++; $display("[TB] FAIL after_reset: got %0d/%0d/%b expected 0/0/0", StallCycles, FlushCount, MemTimeoutM);
    end
    test_watchdog("post_reset_wd");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_reset();
    set_idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_watchdog("watchdog");
    test_random();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
